// File: rtl/fila_ctrl_if.sv
// fila_ctrl_if: handshake and queue-side bus of the fila sequencing controller.
// master = producers, consumer and the fila queue (the environment).
// slave  = fila_ctrl itself.
`timescale 1ns/1ps
interface fila_ctrl_if #(parameter int DW = 8);
  // Producer A write port
  logic          req_a;
  logic [DW-1:0] data_a;
  logic          ack_a;
  // Producer B write port
  logic          req_b;
  logic [DW-1:0] data_b;
  logic          ack_b;
  // Consumer read port
  logic          rd_req;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  // fila queue side
  logic [DW-1:0] fila_data;
  logic          fila_enq;
  logic          fila_deq;
  logic [DW-1:0] fila_dout;

  modport master (
    output req_a, data_a, req_b, data_b, rd_req, fila_dout,
    input  ack_a, ack_b, rd_valid, rd_data, fila_data, fila_enq, fila_deq
  );

  modport slave (
    input  req_a, data_a, req_b, data_b, rd_req, fila_dout,
    output ack_a, ack_b, rd_valid, rd_data, fila_data, fila_enq, fila_deq
  );
endinterface

// File: rtl/fila_ctrl.sv
// fila_ctrl: serialises two producers and one consumer onto the 8-entry fila
// queue. One queue operation is in flight at a time; reads take priority,
// writers are served round-robin. Keeps an exact occupancy count because the
// queue's own length output lags by a cycle.
// Optional build macro FILA_CTRL_STATS_EN: saturating enqueue/dequeue totals.
`timescale 1ns/1ps
module fila_ctrl #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic         clk_10KHz,
  input  logic         reset,
  fila_ctrl_if.slave   bus,
  output logic [7:0]   count,
  output logic         full,
  output logic         empty,
  output logic [7:0]   enq_total,
  output logic [7:0]   deq_total
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENQ   = 3'd1,
    S_DEQ   = 3'd2,
    S_SHIFT = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  localparam logic       SEL_A   = 1'b0;
  localparam logic       SEL_B   = 1'b1;
  localparam logic [7:0] DEPTH_C = 8'(DEPTH);

  state_e        state_q, state_d;
  logic          winner_q, winner_d;   // producer granted for the current ENQ
  logic          rr_last_q;            // producer granted most recently
  logic [7:0]    count_q;
  logic [DW-1:0] rd_data_q;

  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == 8'd0);

  // State register: FSM state plus the grant decided in IDLE.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of the order blocks are evaluated.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      winner_q <= SEL_A;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
    end
  end

  // Next-state logic: arbitration happens only in IDLE, reads first.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    case (state_q)
      S_IDLE: begin
        if (bus.rd_req && !empty) begin
          state_d = S_DEQ;
        end else if ((bus.req_a || bus.req_b) && !full) begin
          state_d  = S_ENQ;
          // Tie goes to whoever was not served last; otherwise the lone requester.
          winner_d = (bus.req_a && bus.req_b) ? ~rr_last_q : bus.req_b;
        end
      end
      S_ENQ:   state_d = S_IDLE;
      S_DEQ:   state_d = S_SHIFT;
      S_SHIFT: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: Moore strobes from the state registers; write data is the
  // granted producer's word as presented during the ENQ cycle.
  always_comb begin
    bus.ack_a     = 1'b0;
    bus.ack_b     = 1'b0;
    bus.fila_enq  = 1'b0;
    bus.fila_deq  = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.fila_data = '0;
    case (state_q)
      S_ENQ: begin
        bus.fila_enq  = 1'b1;
        bus.ack_a     = (winner_q == SEL_A);
        bus.ack_b     = (winner_q == SEL_B);
        bus.fila_data = (winner_q == SEL_B) ? bus.data_b : bus.data_a;
      end
      S_DEQ:   bus.fila_deq = 1'b1;
      S_RESP:  bus.rd_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: occupancy, round-robin history and captured read word.
  // fila presents the dequeued word during SHIFT, so it is captured there.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      count_q   <= 8'd0;
      rr_last_q <= SEL_B;
      rd_data_q <= '0;
    end else begin
      if (state_q == S_ENQ) begin
        rr_last_q <= winner_q;
        if (count_q != DEPTH_C) count_q <= count_q + 8'd1;
      end
      if (state_q == S_SHIFT) begin
        rd_data_q <= bus.fila_dout;
        if (count_q != 8'd0) count_q <= count_q - 8'd1;
      end
    end
  end

  assign bus.rd_data = rd_data_q;

`ifdef FILA_CTRL_STATS_EN
  logic [7:0] enq_total_q, deq_total_q;

  // Saturating totals: one per ENQ cycle, one per SHIFT cycle.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      enq_total_q <= 8'd0;
      deq_total_q <= 8'd0;
    end else begin
      if (state_q == S_ENQ && enq_total_q != 8'hFF)   enq_total_q <= enq_total_q + 8'd1;
      if (state_q == S_SHIFT && deq_total_q != 8'hFF) deq_total_q <= deq_total_q + 8'd1;
    end
  end

  assign enq_total = enq_total_q;
  assign deq_total = deq_total_q;
`else
  assign enq_total = 8'd0;
  assign deq_total = 8'd0;
`endif

endmodule

// File: tb/tb_fila_ctrl.sv
// tb_fila_ctrl: self-checking bench for fila_ctrl with a behavioural fila
// queue (capture on dequeue_in, shift the following cycle) and a scoreboard
// of words expected back from reads.
`timescale 1ns/1ps
module tb_fila_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] count, enq_total, deq_total;
  logic       full, empty;

  fila_ctrl_if #(.DW(8)) bus ();

  fila_ctrl #(.DEPTH(8), .DW(8)) dut (
    .clk_10KHz (clk),
    .reset     (reset),
    .bus       (bus),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .enq_total (enq_total),
    .deq_total (deq_total)
  );

  always #50 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb[$];   // words expected from reads, in order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural fila queue ----------------
  logic [7:0] fq[$];
  logic       shift_pend;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fq.delete();
      shift_pend    <= 1'b0;
      bus.fila_dout <= 8'h00;
    end else begin
      if (shift_pend && fq.size() > 0) void'(fq.pop_front());
      if (bus.fila_enq) fq.push_back(bus.fila_data);
      if (bus.fila_deq) bus.fila_dout <= (fq.size() > 0) ? fq[0] : 8'h00;
      shift_pend <= bus.fila_deq;
    end
  end

  // ---------------- protocol monitor ----------------
  int cyc = 0, last_enq = -100, last_deq = -100;
  int spacing_err = 0, ovf_err = 0, deq_cnt = 0;
  always @(negedge clk) begin
    cyc++;
    if (bus.fila_enq) begin
      if (cyc - last_deq < 2) spacing_err++;
      last_enq = cyc;
    end
    if (bus.fila_deq) begin
      if (cyc - last_enq < 2) spacing_err++;
      last_deq = cyc;
      deq_cnt++;
    end
    if (count > 8'd8) ovf_err++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_write(input logic sel, input logic [7:0] d, input int budget,
                          output logic done, output int lat);
    done = 1'b0;
    lat  = 0;
    if (sel) begin bus.req_b = 1'b1; bus.data_b = d; end
    else     begin bus.req_a = 1'b1; bus.data_a = d; end
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((sel ? bus.ack_b : bus.ack_a) === 1'b1) begin
        done = 1'b1;
        lat  = i;
        check("wr_fila_enq", bus.fila_enq, 1);
        check("wr_fila_data", bus.fila_data, d);
        check("wr_other_ack", sel ? bus.ack_a : bus.ack_b, 0);
        sb.push_back(d);
        break;
      end
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_read(input int budget, output logic done, output int lat);
    logic [7:0] exp;
    done = 1'b0;
    lat  = 0;
    bus.rd_req = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.rd_valid === 1'b1) begin
        done = 1'b1;
        lat  = i;
        if (sb.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          exp = sb.pop_front();
          check("rd_data", bus.rd_data, exp);
        end
        break;
      end
    end
    bus.rd_req = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef enum logic [1:0] {OP_WA, OP_WB, OP_RD} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] data;
    logic       exp_done;
    logic [7:0] exp_count;
    logic       exp_empty;
    logic       exp_full;
  } vec_t;
  vec_t vecs[12];

  initial begin : main
    logic done;
    int   lat, k, rv_cyc, ack_cyc, deq_cyc, deq_before;
    logic [7:0] exp;

    // Fill the table: empty read, write/read 0x5C, fill to 8, blocked write.
    vecs[0] = '{OP_RD, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0};
    vecs[1] = '{OP_WA, 8'h5C, 1'b1, 8'd1, 1'b0, 1'b0};
    vecs[2] = '{OP_RD, 8'h00, 1'b1, 8'd0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++)
      vecs[3+i] = '{OP_WA, 8'(i + 1), 1'b1, 8'(i + 1), 1'b0, (i == 7)};
    vecs[11] = '{OP_WB, 8'hBB, 1'b0, 8'd8, 1'b0, 1'b1};

    reset = 1'b1;
    bus.req_a = 1'b0; bus.data_a = 8'h00;
    bus.req_b = 1'b0; bus.data_b = 8'h00;
    bus.rd_req = 1'b0;
    do_reset();

    // Reset state
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_strobes", {bus.ack_a, bus.ack_b, bus.rd_valid, bus.fila_enq, bus.fila_deq}, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_fila_data", bus.fila_data, 0);

    // Single write from A
    do_write(1'b0, 8'h11, 6, done, lat);
    check("w11_done", done, 1);
    check("w11_latency", lat, 1);
    check("w11_count", count, 1);
    check("w11_empty", empty, 0);
    do_read(10, done, lat);
    check("r11_done", done, 1);
    check("r11_latency", lat, 3);

    // Round-robin with both producers held
    do_reset();
    bus.data_a = 8'hA0; bus.data_b = 8'hB0;
    bus.req_a = 1'b1;   bus.req_b = 1'b1;
    k = 0;
    for (int i = 0; i < 20 && k < 4; i++) begin
      @(negedge clk);
      if (bus.ack_a || bus.ack_b) begin
        check($sformatf("rr_grant%0d", k), bus.ack_b, k % 2);
        exp = (k % 2) ? 8'hB0 : 8'hA0;
        check($sformatf("rr_data%0d", k), bus.fila_data, exp);
        sb.push_back(exp);
        k++;
        if (k == 4) begin bus.req_a = 1'b0; bus.req_b = 1'b0; end
      end
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    check("rr_acks", k, 4);
    @(negedge clk);
    check("rr_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      do_read(10, done, lat);
      check("rr_read_done", done, 1);
    end
    check("rr_count_after", count, 0);

    // Table-driven section
    do_reset();
    for (int i = 0; i < 12; i++) begin
      deq_before = deq_cnt;
      if (vecs[i].op == OP_RD) do_read(10, done, lat);
      else                     do_write(vecs[i].op == OP_WB, vecs[i].data, 6, done, lat);
      check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
      check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].exp_empty);
      check($sformatf("vec%0d_full", i), full, vecs[i].exp_full);
      if (vecs[i].op == OP_RD && !vecs[i].exp_done)
        check($sformatf("vec%0d_no_deq", i), deq_cnt - deq_before, 0);
    end

    // Full: held B write waits behind a read that frees space
    bus.data_b = 8'hBB; bus.req_b = 1'b1; bus.rd_req = 1'b1;
    rv_cyc = 0; ack_cyc = 0;
    for (int i = 1; i <= 20 && ack_cyc == 0; i++) begin
      @(negedge clk);
      if (bus.rd_valid) begin
        rv_cyc = i;
        exp = sb.pop_front();
        check("full_rd_data", bus.rd_data, exp);
        bus.rd_req = 1'b0;
      end
      if (bus.ack_b) begin
        ack_cyc = i;
        check("full_ackb_data", bus.fila_data, 8'hBB);
        sb.push_back(8'hBB);
        bus.req_b = 1'b0;
      end
    end
    bus.req_b = 1'b0; bus.rd_req = 1'b0;
    check("full_rv_cycle", rv_cyc, 3);
    check("full_ackb_cycle", ack_cyc, 5);
    @(negedge clk);
    check("full_count", count, 8);
    check("full_flag", full, 1);
    for (int i = 0; i < 8; i++) begin
      do_read(10, done, lat);
      check("drain_done", done, 1);
    end
    check("drain_empty", empty, 1);

    // Simultaneous read and write with two entries: read served first
    do_reset();
    do_write(1'b0, 8'h21, 6, done, lat);
    do_write(1'b0, 8'h22, 6, done, lat);
    check("mix_count", count, 2);
    bus.data_a = 8'h33; bus.req_a = 1'b1; bus.rd_req = 1'b1;
    deq_before = deq_cnt;
    deq_cyc = 0; rv_cyc = 0; ack_cyc = 0;
    for (int i = 1; i <= 15 && ack_cyc == 0; i++) begin
      @(negedge clk);
      if (bus.fila_deq && deq_cyc == 0) deq_cyc = i;
      if (bus.rd_valid) begin
        rv_cyc = i;
        exp = sb.pop_front();
        check("mix_rd_data", bus.rd_data, exp);
        bus.rd_req = 1'b0;
      end
      if (bus.ack_a) begin
        ack_cyc = i;
        check("mix_wr_data", bus.fila_data, 8'h33);
        sb.push_back(8'h33);
        bus.req_a = 1'b0;
      end
    end
    bus.req_a = 1'b0; bus.rd_req = 1'b0;
    check("mix_deq_cycle", deq_cyc, 1);
    check("mix_deq_pulses", deq_cnt - deq_before, 1);
    check("mix_rv_cycle", rv_cyc, 3);
    check("mix_ack_cycle", ack_cyc, 5);
    @(negedge clk);
    check("mix_count_after", count, 2);

    // Reset asserted while in SHIFT
    bus.rd_req = 1'b1;
    @(negedge clk);
    check("shift_pre_deq", bus.fila_deq, 1);
    @(posedge clk);
    #10;
    reset = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_rd_data", bus.rd_data, 0);
    check("arst_strobes", {bus.ack_a, bus.ack_b, bus.rd_valid, bus.fila_enq, bus.fila_deq}, 0);
    bus.rd_req = 1'b0;
    do_reset();

    // Back in IDLE: first write acked after one cycle; stats
    do_write(1'b0, 8'h01, 6, done, lat);
    check("post_rst_latency", lat, 1);
    do_write(1'b1, 8'h02, 6, done, lat);
    do_write(1'b0, 8'h03, 6, done, lat);
    do_read(10, done, lat);
    check("post_rst_read", done, 1);
    check("post_rst_count", count, 2);
`ifdef FILA_CTRL_STATS_EN
    check("stats_enq_total", enq_total, 3);
    check("stats_deq_total", deq_total, 1);
`else
    check("stats_enq_total", enq_total, 0);
    check("stats_deq_total", deq_total, 0);
`endif

    check("enq_deq_spacing", spacing_err, 0);
    check("count_overflow", ovf_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
